// File: rtl/instr_prefetch.sv
// Instruction prefetch unit.
// Issues word requests to a synchronous instruction ROM (registered read data one cycle after
// the request), buffers the returned words together with their byte addresses in a small FIFO,
// and presents them to the core over a valid/ready handshake. A redirect flushes the buffer and
// any in-flight request, and restarts fetching at the new address.
//
// Ports:
//   HCLK, HRESET     clock, asynchronous active-high reset
//   rom_cs/rom_addr  ROM request strobe and byte address
//   rom_rdata        ROM read data for the request issued in the previous cycle
//   fetch_en         permits new requests
//   redirect,        one-cycle flush-and-restart pulse and its target address
//   redirect_addr
//   instr_valid/     FIFO head presented to the core; instr_ready pops it
//   instr_rdata/
//   instr_addr/
//   instr_ready
//   busy             a request is in flight or the FIFO holds entries
module instr_prefetch #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic        rom_cs,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        instr_valid,
  output logic [31:0] instr_rdata,
  output logic [31:0] instr_addr,
  input  logic        instr_ready,
  output logic        busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_addr_q, inflight_addr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     addr_q [DEPTH];

  logic [CntW:0]   occupancy;
  logic            issue, push, pop;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^redirect_addr[1:0];

  // Credit check counts the in-flight slot; a pop in this cycle earns no extra credit.
  assign occupancy = {1'b0, count_q} + (CntW + 1)'(inflight_q);
  assign issue     = fetch_en & ~redirect & ~HRESET & (occupancy < DepthW);
  assign push      = inflight_q & ~redirect;
  assign pop       = instr_valid & instr_ready;

  assign rom_cs      = issue;
  assign rom_addr    = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_rdata = data_q[rd_ptr_q];
  assign instr_addr  = addr_q[rd_ptr_q];
  assign busy        = inflight_q | instr_valid;

  always_comb begin
    pc_d            = pc_q;
    inflight_d      = issue;
    inflight_addr_d = inflight_addr_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;

    if (issue) begin
      pc_d            = pc_q + 32'd4;
      inflight_addr_d = pc_q;
    end

    if (redirect) begin
      // A coincident pop of the old head completes; everything else is dropped.
      pc_d     = {redirect_addr[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pc_q            <= BOOT_ADDR;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      if (push) begin
        data_q[wr_ptr_q] <= rom_rdata;
        addr_q[wr_ptr_q] <= inflight_addr_q;
      end
    end
  end

endmodule
